// File: rtl/forth_data_stack.sv
`default_nettype none
// ============================================================================
// Module   : forth_data_stack
// Brief    : Forth data-stack controller. Keeps TOS/NOS in registers and the
//            deeper cells in a register array, executes stack primitives and
//            ALU words through an external combinational ALU, and reports
//            sticky stack/operand faults.
// Options  : FORTH_DSTACK_DIVZ_TRAP_EN - trap ALU ops 4 (/) and 5 (%) with
//            TOS == 0 at accept (err 4) instead of issuing them to the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module forth_data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [3:0]                 cmd_aluop,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [3:0]                 alu_op,
    input  logic [WIDTH-1:0]           alu_res,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    input  logic                       err_clr,
    output logic [2:0]                 err_code
);

    localparam int C_DW  = $clog2(DEPTH+1);
    // Cells below NOS; keep at least one entry so DEPTH == 2 still elaborates.
    localparam int C_MEM = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int C_AW  = (C_MEM > 1) ? $clog2(C_MEM) : 1;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_exec = 1'b1;

    localparam logic [2:0] c_op_nop  = 3'd0;
    localparam logic [2:0] c_op_push = 3'd1;
    localparam logic [2:0] c_op_drop = 3'd2;
    localparam logic [2:0] c_op_dup  = 3'd3;
    localparam logic [2:0] c_op_swap = 3'd4;
    localparam logic [2:0] c_op_over = 3'd5;
    localparam logic [2:0] c_op_alu  = 3'd6;

    localparam logic [2:0] c_err_none  = 3'd0;
    localparam logic [2:0] c_err_under = 3'd1;
    localparam logic [2:0] c_err_over  = 3'd2;
    localparam logic [2:0] c_err_badop = 3'd3;
    localparam logic [2:0] c_err_divz  = 3'd4;

    logic [0:0]       r_state;
    logic [C_DW-1:0]  r_depth;
    logic [WIDTH-1:0] r_tos;
    logic [WIDTH-1:0] r_nos;
    logic [WIDTH-1:0] r_mem [C_MEM];
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_unary;
    logic [2:0]       r_err;

    logic             w_accept;
    logic             w_unary;
    logic             w_grows;
    logic [1:0]       w_need;
    logic             w_full;
    logic             w_divz;
    logic [2:0]       w_fault_code;
    logic             w_fault;
    logic             w_do;
    logic             w_mem_we;
    logic [C_AW-1:0]  w_wr_idx;
    logic [C_AW-1:0]  w_rd_idx;
    logic [WIDTH-1:0] w_below;

    assign cmd_ready = (r_state == c_idle);
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_unary   = (cmd_aluop == 4'd9) || (cmd_aluop == 4'd10);
    assign w_grows   = (cmd_op == c_op_push) || (cmd_op == c_op_dup) || (cmd_op == c_op_over);
    assign w_full    = (r_depth == C_DW'(DEPTH));

`ifdef FORTH_DSTACK_DIVZ_TRAP_EN
    assign w_divz = (cmd_op == c_op_alu) && ((cmd_aluop == 4'd4) || (cmd_aluop == 4'd5))
                    && (r_tos == '0);
`else
    assign w_divz = 1'b0;
`endif

    // Minimum stack depth each command needs before it may execute.
    always_comb begin
        w_need = 2'd0;
        case (cmd_op)
            c_op_drop, c_op_dup:  w_need = 2'd1;
            c_op_swap, c_op_over: w_need = 2'd2;
            c_op_alu:             w_need = w_unary ? 2'd1 : 2'd2;
            default:              w_need = 2'd0;
        endcase
    end

    // Fault classification: bad opcode first, then underflow, overflow, divide trap.
    always_comb begin
        w_fault_code = c_err_none;
        if ((cmd_op == 3'd7) || ((cmd_op == c_op_alu) && (cmd_aluop == 4'd0)))
            w_fault_code = c_err_badop;
        else if (r_depth < C_DW'(w_need))
            w_fault_code = c_err_under;
        else if (w_grows && w_full)
            w_fault_code = c_err_over;
        else if (w_divz)
            w_fault_code = c_err_divz;
    end

    assign w_fault  = w_accept & (w_fault_code != c_err_none);
    assign w_do     = w_accept & (w_fault_code == c_err_none);

    // Array slot just below NOS: written on growth, read back on shrink.
    assign w_wr_idx = C_AW'(r_depth - C_DW'(2));
    assign w_rd_idx = C_AW'(r_depth - C_DW'(3));
    assign w_mem_we = w_do & w_grows & (r_depth >= C_DW'(2));
    assign w_below  = (r_depth >= C_DW'(3)) ? r_mem[w_rd_idx] : '0;

    // Spill NOS into the array whenever the stack grows past two cells.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_wr_idx] <= r_nos;
    end

    // Sticky error register: first fault wins; a clear coinciding with a fault loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= c_err_none;
        else if (w_fault && ((r_err == c_err_none) || err_clr))
            r_err <= w_fault_code;
        else if (err_clr)
            r_err <= c_err_none;
    end

    // Controller FSM: stack primitives complete in IDLE, ALU words spend one cycle in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_depth  <= '0;
            r_tos    <= '0;
            r_nos    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 4'd0;
            r_unary  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_do) begin
                        case (cmd_op)
                            c_op_push: begin
                                r_tos   <= cmd_data;
                                r_nos   <= r_tos;
                                r_depth <= r_depth + C_DW'(1);
                            end
                            c_op_drop: begin
                                r_tos   <= r_nos;
                                r_nos   <= w_below;
                                r_depth <= r_depth - C_DW'(1);
                            end
                            c_op_dup: begin
                                r_nos   <= r_tos;
                                r_depth <= r_depth + C_DW'(1);
                            end
                            c_op_swap: begin
                                r_tos <= r_nos;
                                r_nos <= r_tos;
                            end
                            c_op_over: begin
                                r_tos   <= r_nos;
                                r_nos   <= r_tos;
                                r_depth <= r_depth + C_DW'(1);
                            end
                            c_op_alu: begin
                                r_alu_a  <= r_nos;
                                r_alu_b  <= r_tos;
                                r_alu_op <= cmd_aluop;
                                r_unary  <= w_unary;
                                r_state  <= c_exec;
                            end
                            default: ; // NOP
                        endcase
                    end
                end
                c_exec: begin
                    r_tos    <= alu_res;
                    if (!r_unary) begin
                        r_nos   <= w_below;
                        r_depth <= r_depth - C_DW'(1);
                    end
                    r_alu_op <= 4'd0;
                    r_state  <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign tos      = (r_depth == '0) ? '0 : r_tos;
    assign depth    = r_depth;
    assign err_code = r_err;

endmodule
`default_nettype wire
